// File: rtl/fetch_unit_pkg.sv
// Shared GPU definitions: opcodes and the fetch FSM state type.
// Also imported by the pipeline and decoder.
package fetch_unit_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_BR  = 4'hC;
  localparam logic [3:0] OP_RET = 4'hF;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQUEST,
    FS_OUTPUT,
    FS_HALTED
  } fetch_state_e;

  function automatic logic is_ret(input logic [3:0] op);
    return op == OP_RET;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding program-memory read at a time,
// redirect on flush, stops after a consumed RET.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int INSTR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_BITS-1:0]  redirect_pc,
  input  logic                  pipeline_stall,
  output logic                  mem_read_valid,
  output logic [ADDR_BITS-1:0]  mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [INSTR_BITS-1:0] mem_read_data,
  output logic [INSTR_BITS-1:0] fetched_instruction,
  output logic                  fetch_valid,
  output logic [ADDR_BITS-1:0]  fetch_pc,
  output logic                  halted
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic                  req_q, req_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [INSTR_BITS-1:0] instr_q, instr_d;
  logic                  fv_q, fv_d;
  logic [ADDR_BITS-1:0]  fpc_q, fpc_d;
  logic                  halted_q, halted_d;

  logic                  consume;
  logic [ADDR_BITS-1:0]  pc_inc;

  assign consume = fv_q & enable & ~pipeline_stall & ~flush;
  assign pc_inc  = pc_q + ADDR_BITS'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    fv_d      = fv_q;
    fpc_d     = fpc_q;
    halted_d  = halted_q;
    unique case (state_q)
      FS_IDLE: begin
        if (flush) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          state_d = FS_REQUEST;
        end else if (enable) begin
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = FS_REQUEST;
        end
      end
      FS_REQUEST: begin
        if (mem_read_ready) begin
          if (flush || discard_q) begin
            // stale response: drop it, re-issue at the redirect target
            discard_d = 1'b0;
            pc_d      = flush ? redirect_pc : pc_q;
            addr_d    = flush ? redirect_pc : pc_q;
          end else begin
            instr_d = mem_read_data;
            fpc_d   = pc_q;
            req_d   = 1'b0;
            fv_d    = 1'b1;
            state_d = FS_OUTPUT;
          end
        end else if (flush) begin
          // address stays stable until the pending handshake ends
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
      end
      FS_OUTPUT: begin
        if (flush) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          fv_d    = 1'b0;
          state_d = FS_REQUEST;
        end else if (consume) begin
          pc_d = pc_inc;
          fv_d = 1'b0;
          if (is_ret(instr_q[15:12])) begin
            halted_d = 1'b1;
            state_d  = FS_HALTED;
          end else begin
            addr_d  = pc_inc;
            req_d   = 1'b1;
            state_d = FS_REQUEST;
          end
        end
      end
      FS_HALTED: begin
        if (flush) begin
          pc_d     = redirect_pc;
          addr_d   = redirect_pc;
          req_d    = 1'b1;
          halted_d = 1'b0;
          state_d  = FS_REQUEST;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FS_IDLE;
      pc_q      <= '0;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      instr_q   <= '0;
      fv_q      <= 1'b0;
      fpc_q     <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      fv_q      <= fv_d;
      fpc_q     <= fpc_d;
      halted_q  <= halted_d;
    end
  end

  assign mem_read_valid      = req_q;
  assign mem_read_address    = addr_q;
  assign fetched_instruction = instr_q;
  assign fetch_valid         = fv_q;
  assign fetch_pc            = fpc_q;
  assign halted              = halted_q;

endmodule
